// File: rtl/pipe_adder_pkg.sv
// Shared configuration for the pipelined multi-precision adder:
// default widths, segment-count derivation and the configuration check.
package pipe_adder_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_SEG_W = 32;

    function automatic int calc_nseg(input int width, input int seg_w);
        return (seg_w > 0) ? (width / seg_w) : 1;
    endfunction

    function automatic bit cfg_ok(input int width, input int seg_w);
        return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle: master is the producer/consumer side,
// slave is the adder itself.
interface pipe_adder_if
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, operand1, operand2, cin, sub, out_ready,
        input  in_ready, out_valid, result, cout, overflow
    );

    modport slave (
        input  in_valid, operand1, operand2, cin, sub, out_ready,
        output in_ready, out_valid, result, cout, overflow
    );

endinterface

// File: rtl/pipe_adder_adder_seg.sv
// One segment of the ripple: SEG_W-bit combinational add with carry in/out.
module adder_seg
    import pipe_adder_pkg::*;
#(
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             ci,
    output logic [SEG_W-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, ci};

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: one SEG_W segment per stage, carry registered
// between stages, whole pipeline advances together under valid/ready.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic        clk,
    input  logic        resetn,
    pipe_adder_if.slave bus
);

    localparam int NSEG = calc_nseg(WIDTH, SEG_W);

    if (!cfg_ok(WIDTH, SEG_W)) begin : g_cfg_check
        $error("pipe_adder: WIDTH must be a non-zero multiple of SEG_W");
    end

    logic             adv;
    logic [WIDTH-1:0] st_acc [NSEG];
    logic [WIDTH-1:0] st_b   [NSEG];
    logic [NSEG-1:0]  st_c;
    logic [NSEG-1:0]  st_v;
    logic             ovf_out;

    // Whole pipe moves or holds as one; depends only on the output side.
    assign adv          = !st_v[NSEG-1] || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
        logic [WIDTH-1:0] acc_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] acc_d;
        logic [WIDTH-1:0] acc_q;
        logic [WIDTH-1:0] b_q;
        logic [SEG_W-1:0] seg_s;
        logic             c_in;
        logic             v_in;
        logic             seg_co;
        logic             c_q;
        logic             v_q;

        if (gi == 0) begin : g_head
            // Subtract is A + ~B + ~borrow_in.
            assign acc_in = bus.operand1;
            assign b_in   = bus.sub ? ~bus.operand2 : bus.operand2;
            assign c_in   = bus.cin ^ bus.sub;
            assign v_in   = bus.in_valid;
        end else begin : g_link
            assign acc_in = st_acc[gi-1];
            assign b_in   = st_b[gi-1];
            assign c_in   = st_c[gi-1];
            assign v_in   = st_v[gi-1];
        end

        adder_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a  (acc_in[gi*SEG_W +: SEG_W]),
            .b  (b_in[gi*SEG_W +: SEG_W]),
            .ci (c_in),
            .s  (seg_s),
            .co (seg_co)
        );

        // Low segments hold finished sums, high segments still hold operand A.
        always_comb begin
            acc_d                       = acc_in;
            acc_d[gi*SEG_W +: SEG_W]    = seg_s;
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                acc_q <= '0;
                b_q   <= '0;
            end else if (adv) begin
                v_q   <= v_in;
                c_q   <= seg_co;
                acc_q <= acc_d;
                b_q   <= b_in;
            end
        end

        assign st_acc[gi] = acc_q;
        assign st_b[gi]   = b_q;
        assign st_c[gi]   = c_q;
        assign st_v[gi]   = v_q;

        if (gi == NSEG - 1) begin : g_tail
            logic ovf_q;

            // The top segment of A and B' is still intact at the last stage input.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= (acc_in[WIDTH-1] == b_in[WIDTH-1])
                          && (seg_s[SEG_W-1] != acc_in[WIDTH-1]);
                end
            end

            assign ovf_out = ovf_q;
        end
    end

    assign bus.out_valid = st_v[NSEG-1];
    assign bus.result    = st_acc[NSEG-1];
    assign bus.cout      = st_c[NSEG-1];
    assign bus.overflow  = ovf_out;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed and streaming checks of pipe_adder at 64/32, 32/32 and 128/32.
module tb_pipe_adder;

    typedef logic [129:0] rv_t;  // {overflow, cout, result zero-extended to 128}

    logic clk = 1'b0;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(64))  if64 ();
    pipe_adder_if #(.WIDTH(32))  if32 ();
    pipe_adder_if #(.WIDTH(128)) if128 ();

    pipe_adder #(.WIDTH(64),  .SEG_W(32)) u_d64  (.clk(clk), .resetn(resetn), .bus(if64.slave));
    pipe_adder #(.WIDTH(32),  .SEG_W(32)) u_d32  (.clk(clk), .resetn(resetn), .bus(if32.slave));
    pipe_adder #(.WIDTH(128), .SEG_W(32)) u_d128 (.clk(clk), .resetn(resetn), .bus(if128.slave));

    rv_t          q64[$];
    rv_t          q32[$];
    rv_t          q128[$];
    logic [127:0] op_a [24];
    logic [127:0] op_b [24];
    logic         op_c [24];
    logic         op_s [24];

    task automatic chk(input string tag, input rv_t got, input rv_t exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic rv_t model(input logic [127:0] a, input logic [127:0] b,
                                  input logic c, input logic s, input int w);
        logic [128:0] mask;
        logic [128:0] aa;
        logic [128:0] bb;
        logic [128:0] full;
        logic         sa;
        logic         sb;
        logic         sr;
        logic         ovf;
        mask = (129'd1 << w) - 129'd1;
        aa   = {1'b0, a} & mask;
        bb   = {1'b0, (s ? ~b : b)} & mask;
        full = aa + bb + {128'd0, (s ? ~c : c)};
        sa   = aa[w-1];
        sb   = b[w-1];
        sr   = full[w-1];
        ovf  = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        return {ovf, full[w], full[127:0] & mask[127:0]};
    endfunction

    task automatic drive_idle();
        if64.in_valid  = 1'b0; if64.out_ready  = 1'b1; if64.operand1  = '0; if64.operand2  = '0;
        if64.cin       = 1'b0; if64.sub        = 1'b0;
        if32.in_valid  = 1'b0; if32.out_ready  = 1'b1; if32.operand1  = '0; if32.operand2  = '0;
        if32.cin       = 1'b0; if32.sub        = 1'b0;
        if128.in_valid = 1'b0; if128.out_ready = 1'b1; if128.operand1 = '0; if128.operand2 = '0;
        if128.cin      = 1'b0; if128.sub       = 1'b0;
    endtask

    // One isolated op through the 64-bit unit, checking latency and outputs.
    task automatic send64(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic c, input logic s, input logic [63:0] er,
                          input logic ec, input logic eo);
        int lat;
        @(posedge clk); #1;
        if64.operand1 = a; if64.operand2 = b; if64.cin = c; if64.sub = s;
        if64.in_valid = 1'b1; if64.out_ready = 1'b1;
        chk({tag, "_in_ready"}, rv_t'(if64.in_ready), rv_t'(1));
        @(posedge clk); #1;
        if64.in_valid = 1'b0;
        lat = 1;
        while (!if64.out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, rv_t'(lat), rv_t'(2));
        chk(tag, {if64.overflow, if64.cout, 64'd0, if64.result}, {eo, ec, 64'd0, er});
        $display("op %s: result=%h cout=%b ovf=%b latency=%0d", tag, if64.result,
                 if64.cout, if64.overflow, lat);
    endtask

    // Stream nops ops. bp=1: 64-bit unit only, output stalled on cycles 3..7.
    // bp=0: all three units, random output backpressure.
    task automatic run_stream(input int nops, input bit bp);
        int  sent64 = 0, sent32 = 0, sent128 = 0;
        int  got64 = 0, got32 = 0, got128 = 0;
        bit  acc64 = 0, acc32 = 0, acc128 = 0;
        bit  done = 0;
        rv_t exp;
        for (int i = 0; i < nops; i++) begin
            op_a[i] = {$urandom, $urandom, $urandom, $urandom};
            op_b[i] = {$urandom, $urandom, $urandom, $urandom};
            op_c[i] = 1'($urandom_range(0, 1));
            op_s[i] = 1'($urandom_range(0, 1));
        end
        q64.delete(); q32.delete(); q128.delete();
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(posedge clk); #1;
            if64.out_ready = bp ? !(cyc >= 3 && cyc <= 7) : ($urandom_range(0, 3) != 0);
            if (!bp) begin
                if32.out_ready  = ($urandom_range(0, 3) != 0);
                if128.out_ready = ($urandom_range(0, 3) != 0);
            end
            if (bp && cyc == 5) begin
                chk("bp_full_in_ready", rv_t'(if64.in_ready), rv_t'(0));
                chk("bp_full_out_valid", rv_t'(if64.out_valid), rv_t'(1));
            end
            if (!if64.in_valid || acc64) begin
                if (sent64 < nops) begin
                    if64.in_valid = 1'b1; if64.operand1 = op_a[sent64][63:0];
                    if64.operand2 = op_b[sent64][63:0]; if64.cin = op_c[sent64];
                    if64.sub = op_s[sent64]; sent64++;
                end else if64.in_valid = 1'b0;
            end
            if (!bp && (!if32.in_valid || acc32)) begin
                if (sent32 < nops) begin
                    if32.in_valid = 1'b1; if32.operand1 = op_a[sent32][31:0];
                    if32.operand2 = op_b[sent32][31:0]; if32.cin = op_c[sent32];
                    if32.sub = op_s[sent32]; sent32++;
                end else if32.in_valid = 1'b0;
            end
            if (!bp && (!if128.in_valid || acc128)) begin
                if (sent128 < nops) begin
                    if128.in_valid = 1'b1; if128.operand1 = op_a[sent128];
                    if128.operand2 = op_b[sent128]; if128.cin = op_c[sent128];
                    if128.sub = op_s[sent128]; sent128++;
                end else if128.in_valid = 1'b0;
            end
            @(negedge clk);
            if (if64.out_valid && if64.out_ready) begin
                chk("s64_expected_pending", rv_t'(q64.size() != 0), rv_t'(1));
                exp = (q64.size() != 0) ? q64.pop_front() : '0;
                chk("s64", {if64.overflow, if64.cout, 64'd0, if64.result}, exp);
                $display("w64 out #%0d: result=%h cout=%b ovf=%b", got64, if64.result, if64.cout, if64.overflow);
                got64++;
            end
            if (if32.out_valid && if32.out_ready) begin
                chk("s32_expected_pending", rv_t'(q32.size() != 0), rv_t'(1));
                exp = (q32.size() != 0) ? q32.pop_front() : '0;
                chk("s32", {if32.overflow, if32.cout, 96'd0, if32.result}, exp);
                $display("w32 out #%0d: result=%h cout=%b ovf=%b", got32, if32.result, if32.cout, if32.overflow);
                got32++;
            end
            if (if128.out_valid && if128.out_ready) begin
                chk("s128_expected_pending", rv_t'(q128.size() != 0), rv_t'(1));
                exp = (q128.size() != 0) ? q128.pop_front() : '0;
                chk("s128", {if128.overflow, if128.cout, if128.result}, exp);
                $display("w128 out #%0d: result=%h cout=%b ovf=%b", got128, if128.result, if128.cout, if128.overflow);
                got128++;
            end
            acc64  = if64.in_valid && if64.in_ready;
            acc32  = if32.in_valid && if32.in_ready;
            acc128 = if128.in_valid && if128.in_ready;
            if (acc64)  q64.push_back(model({64'd0, if64.operand1}, {64'd0, if64.operand2}, if64.cin, if64.sub, 64));
            if (acc32)  q32.push_back(model({96'd0, if32.operand1}, {96'd0, if32.operand2}, if32.cin, if32.sub, 32));
            if (acc128) q128.push_back(model(if128.operand1, if128.operand2, if128.cin, if128.sub, 128));
            done = (got64 == nops) && (bp || (got32 == nops && got128 == nops));
        end
        chk("stream_count64", rv_t'(got64), rv_t'(nops));
        chk("stream_left64", rv_t'(q64.size()), rv_t'(0));
        if (!bp) begin
            chk("stream_count32", rv_t'(got32), rv_t'(nops));
            chk("stream_left32", rv_t'(q32.size()), rv_t'(0));
            chk("stream_count128", rv_t'(got128), rv_t'(nops));
            chk("stream_left128", rv_t'(q128.size()), rv_t'(0));
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    initial begin
        drive_idle();
        resetn = 1'b0;
        #1;
        chk("rst_out_valid64", rv_t'(if64.out_valid), rv_t'(0));
        chk("rst_in_ready64", rv_t'(if64.in_ready), rv_t'(1));
        chk("rst_outputs64", {if64.overflow, if64.cout, 64'd0, if64.result}, rv_t'(0));
        chk("rst_out_valid32", rv_t'(if32.out_valid), rv_t'(0));
        chk("rst_out_valid128", rv_t'(if128.out_valid), rv_t'(0));
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        send64("carry_seg",  64'h00000000_FFFFFFFF, 64'd1, 1'b0, 1'b0, 64'h00000001_00000000, 1'b0, 1'b0);
        send64("full_wrap",  64'hFFFFFFFF_FFFFFFFF, 64'd0, 1'b1, 1'b0, 64'h0,                 1'b1, 1'b0);
        send64("sub_5_7",    64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFE, 1'b0, 1'b0);
        send64("sub_7_5",    64'd7, 64'd5, 1'b0, 1'b1, 64'd2,                 1'b1, 1'b0);
        send64("add_ovf",    64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b0, 1'b0, 64'h80000000_00000000, 1'b0, 1'b1);
        send64("sub_borrow", 64'd0, 64'd0, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0);
        send64("sub_ovf",    64'h80000000_00000000, 64'd1, 1'b0, 1'b1, 64'h7FFFFFFF_FFFFFFFF, 1'b1, 1'b1);
        repeat (2) @(posedge clk);

        run_stream(6, 1'b1);
        run_stream(20, 1'b0);
        repeat (2) @(posedge clk);

        // Two ops in flight, then an asynchronous reset pulse.
        #1;
        if64.operand1 = 64'd3; if64.operand2 = 64'd4; if64.in_valid = 1'b1; if64.out_ready = 1'b1;
        @(posedge clk); #1;
        if64.operand1 = 64'd9; if64.operand2 = 64'd1;
        @(posedge clk); #1;
        if64.in_valid = 1'b0;
        chk("inflight_out_valid", rv_t'(if64.out_valid), rv_t'(1));
        resetn = 1'b0;
        #1;
        chk("midrst_out_valid", rv_t'(if64.out_valid), rv_t'(0));
        chk("midrst_in_ready", rv_t'(if64.in_ready), rv_t'(1));
        chk("midrst_outputs", {if64.overflow, if64.cout, 64'd0, if64.result}, rv_t'(0));
        $display("reset pulse: out_valid=%b in_ready=%b", if64.out_valid, if64.in_ready);
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("postrst_out_valid", rv_t'(if64.out_valid), rv_t'(0));
        end
        send64("post_rst", 64'h10, 64'h20, 1'b0, 1'b0, 64'h30, 1'b0, 1'b0);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
